// File: rtl/encoder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | encoder_pkg : shared widths and FSM state type for the 8x3 encoder  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package encoder_pkg;

  localparam int IN_W   = 8;
  localparam int CODE_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage : encoder_pkg
`default_nettype wire

// File: rtl/prio_enc_8x3.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prio_enc_8x3 : combinational priority encoder (index, mask, single) |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module prio_enc_8x3
  import encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [IN_W-1:0]   i_vec,
  output logic [CODE_W-1:0] o_idx,
  output logic [IN_W-1:0]   o_onehot,
  output logic              o_single
);

  // Later loop iterations win, so the scan direction selects the priority.
  always_comb begin
    o_idx    = '0;
    o_onehot = '0;
    if (LSB_FIRST) begin
      for (int b = IN_W - 1; b >= 0; b--) begin
        if (i_vec[b]) begin
          o_idx    = CODE_W'(b);
          o_onehot = IN_W'(1) << b;
        end
      end
    end else begin
      for (int b = 0; b < IN_W; b++) begin
        if (i_vec[b]) begin
          o_idx    = CODE_W'(b);
          o_onehot = IN_W'(1) << b;
        end
      end
    end
  end

  assign o_single = (i_vec != '0) && ((i_vec & (i_vec - IN_W'(1))) == '0);

endmodule : prio_enc_8x3
`default_nettype wire

// File: rtl/encoder_8x3_serial.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | encoder_8x3_serial : emits the index of every set bit, one per beat |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module encoder_8x3_serial
  import encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out,
  output logic              out_last,
  output logic              zero_flag
);

  state_t            r_state;
  logic [IN_W-1:0]   r_pend;
  logic              r_zero_flag;

  logic [CODE_W-1:0] w_idx;
  logic [IN_W-1:0]   w_onehot;
  logic              w_single;
  logic              w_accept;

  prio_enc_8x3 #(
    .LSB_FIRST (LSB_FIRST)
  ) u_prio (
    .i_vec    (r_pend),
    .o_idx    (w_idx),
    .o_onehot (w_onehot),
    .o_single (w_single)
  );

  assign w_accept = in_valid && (r_state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_zero_flag <= 1'b0;
    end else begin
      r_zero_flag <= w_accept && (i == '0);
      case (r_state)
        IDLE: begin
          if (w_accept && (i != '0)) begin
            r_pend  <= i;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            r_pend <= r_pend & ~w_onehot;
            if (w_single) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // EMIT always holds a non-zero pend, so outputs decode straight from state.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == EMIT);
  assign out       = out_valid ? w_idx : '0;
  assign out_last  = out_valid && w_single;
  assign zero_flag = r_zero_flag;

endmodule : encoder_8x3_serial
`default_nettype wire
